// File: rtl/logic_unit_pkg.sv
// logic_unit_pkg: shared opcode and FSM state types for logic_accum_unit.
//   op_e     - 3-bit opcode (single-beat AND/OR/XOR/NOT, accumulating
//              ACC_AND/ACC_OR/ACC_XOR, reserved)
//   state_e  - reduction FSM state (IDLE, ACCUM)
//   is_accum - true for the accumulating opcodes
package logic_unit_pkg;

  typedef enum logic [2:0] {
    OP_AND     = 3'd0,
    OP_OR      = 3'd1,
    OP_XOR     = 3'd2,
    OP_NOT     = 3'd3,
    OP_ACC_AND = 3'd4,
    OP_ACC_OR  = 3'd5,
    OP_ACC_XOR = 3'd6,
    OP_RSVD    = 3'd7
  } op_e;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_e;

  function automatic logic is_accum(input op_e op);
    return (op == OP_ACC_AND) || (op == OP_ACC_OR) || (op == OP_ACC_XOR);
  endfunction

endpackage

// File: rtl/logic_op_core.sv
// logic_op_core: combinational bitwise function unit.
//   op - opcode (op_e)
//   a  - operand A
//   b  - operand B (the accumulator when folding a reduction)
//   y  - result; NOT yields ~a, the reserved opcode passes a through
module logic_op_core
  import logic_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  op_e              op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = a;
    case (op)
      OP_AND, OP_ACC_AND: y = a & b;
      OP_OR,  OP_ACC_OR:  y = a | b;
      OP_XOR, OP_ACC_XOR: y = a ^ b;
      OP_NOT:             y = ~a;
      default:            y = a;
    endcase
  end

endmodule

// File: rtl/logic_accum_unit.sv
// logic_accum_unit: registered WIDTH-bit bitwise unit with valid/ready
// handshake and multi-beat accumulating reductions.
//   clk, rst_n         - clock, synchronous active-low reset
//   in_valid/in_ready  - operand beat handshake
//   in_op, in_a, in_b  - opcode and operands
//   in_first, in_last  - reduction framing for accumulate opcodes
//   out_valid/out_ready- result handshake
//   out_data, out_any  - result and its OR-reduction
//   out_err            - result came from the reserved opcode
//   out_beats          - beats folded into result (only with
//                        LOGIC_ACCUM_BEAT_COUNT_EN defined)
module logic_accum_unit
  import logic_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_first,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_any,
`ifdef LOGIC_ACCUM_BEAT_COUNT_EN
  output logic [CNT_W-1:0] out_beats,
`endif
  output logic             out_err
);

  op_e              op;
  logic             accum_op;
  logic             accept;
  logic             start;
  logic             load;
  state_e           state, state_next;
  logic [WIDTH-1:0] acc, acc_d, acc_next;
  logic [WIDTH-1:0] core_b, core_y;
  logic [WIDTH-1:0] result;

  assign op       = op_e'(in_op);
  assign accum_op = is_accum(op);
  assign in_ready = rst_n && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  // IDLE without in_first is an implicit start of a new reduction.
  assign start    = in_first || (state == IDLE);

  // One core serves both paths: the fold substitutes the accumulator for B.
  assign core_b = accum_op ? acc : in_b;

  logic_op_core #(.WIDTH(WIDTH)) u_core (
    .op (op),
    .a  (in_a),
    .b  (core_b),
    .y  (core_y)
  );

  assign acc_next = start ? in_a : core_y;
  assign result   = accum_op ? acc_next : core_y;
  assign load     = accept && (!accum_op || in_last);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      acc   <= '0;
    end else begin
      state <= state_next;
      acc   <= acc_d;
    end
  end

  always_comb begin
    state_next = state;
    acc_d      = acc;
    if (accept && accum_op) begin
      if (in_last) begin
        state_next = IDLE;
        acc_d      = '0;
      end else begin
        state_next = ACCUM;
        acc_d      = acc_next;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_any   <= 1'b0;
      out_err   <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= result;
      out_any   <= |result;
      out_err   <= (op == OP_RSVD);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef LOGIC_ACCUM_BEAT_COUNT_EN
  logic [CNT_W-1:0] cnt, cnt_d, cnt_next;

  assign cnt_next = start ? CNT_W'(1)
                  : ((cnt == '1) ? cnt : cnt + CNT_W'(1));

  always_comb begin
    cnt_d = cnt;
    if (accept && accum_op) begin
      cnt_d = in_last ? '0 : cnt_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt       <= '0;
      out_beats <= '0;
    end else begin
      cnt <= cnt_d;
      if (load) begin
        out_beats <= accum_op ? cnt_next : CNT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_logic_accum_unit.sv
module tb_logic_accum_unit;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned CNT_W = 3;

  localparam logic [2:0] AND_OP  = 3'd0;
  localparam logic [2:0] OR_OP   = 3'd1;
  localparam logic [2:0] XOR_OP  = 3'd2;
  localparam logic [2:0] NOT_OP  = 3'd3;
  localparam logic [2:0] AAND_OP = 3'd4;
  localparam logic [2:0] AOR_OP  = 3'd5;
  localparam logic [2:0] AXOR_OP = 3'd6;
  localparam logic [2:0] RSVD_OP = 3'd7;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_op;
  logic [WIDTH-1:0] in_a, in_b;
  logic             in_first, in_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_any;
  logic             out_err;
  logic [CNT_W-1:0] obs_beats;

  typedef struct {
    logic [WIDTH-1:0] data;
    logic             err;
    logic [CNT_W-1:0] beats;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

`ifdef LOGIC_ACCUM_BEAT_COUNT_EN
  logic [CNT_W-1:0] out_beats;
  assign obs_beats = out_beats;
`else
  assign obs_beats = '0;
`endif

  logic_accum_unit #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_first  (in_first),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_any   (out_any),
`ifdef LOGIC_ACCUM_BEAT_COUNT_EN
    .out_beats (out_beats),
`endif
    .out_err   (out_err)
  );

  // Expected beat count only exists when the counter is built in.
  task automatic push(input logic [WIDTH-1:0] d, input logic err,
                      input logic [CNT_W-1:0] beats);
    exp_t x;
    x.data = d;
    x.err  = err;
`ifdef LOGIC_ACCUM_BEAT_COUNT_EN
    x.beats = beats;
`else
    x.beats = (beats == beats) ? '0 : '0;
`endif
    q.push_back(x);
  endtask

  // Drive one beat for one clock; called and returns at a falling edge.
  task automatic send(input logic [2:0] op, input logic [WIDTH-1:0] a,
                      input logic [WIDTH-1:0] b, input logic first,
                      input logic last);
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_first = first;
    in_last  = last;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_first = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || out_any !== 1'b0 ||
        out_err !== 1'b0 || obs_beats !== 3'd0 || in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: got v=%b d=%h any=%b err=%b beats=%0d rdy=%b, want all 0",
               out_valid, out_data, out_any, out_err, obs_beats, in_ready);
    end
    rst_n = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL ready_after_reset: got %b want 1", in_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    push(8'h30, 1'b0, 3'd1);
    send(AND_OP, 8'hF0, 8'h3C, 1'b0, 1'b0);
    e = q.pop_front();
    vectors++;
    if (out_valid !== 1'b1 || out_data !== e.data || out_any !== (|e.data) ||
        out_err !== e.err || obs_beats !== e.beats) begin
      miscompares++;
      $display("FAIL and_f0_3c: got v=%b d=%h any=%b err=%b beats=%0d, want v=1 d=%h err=%b beats=%0d",
               out_valid, out_data, out_any, out_err, obs_beats, e.data, e.err, e.beats);
    end
    push(8'h00, 1'b0, 3'd1);
    send(NOT_OP, 8'hFF, 8'h12, 1'b0, 1'b0);
    e = q.pop_front();
    vectors++;
    if (out_valid !== 1'b1 || out_data !== e.data || out_any !== (|e.data) ||
        out_err !== e.err || obs_beats !== e.beats) begin
      miscompares++;
      $display("FAIL not_ff: got v=%b d=%h any=%b err=%b beats=%0d, want v=1 d=%h err=%b beats=%0d",
               out_valid, out_data, out_any, out_err, obs_beats, e.data, e.err, e.beats);
    end
  endtask

  task automatic test_accum_or();
    send(AOR_OP, 8'h01, 8'hFF, 1'b1, 1'b0);
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL acc_or_beat1_quiet: got out_valid=%b want 0", out_valid);
    end
    send(AOR_OP, 8'h02, 8'hFF, 1'b0, 1'b0);
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL acc_or_beat2_quiet: got out_valid=%b want 0", out_valid);
    end
    push(8'h83, 1'b0, 3'd3);
    send(AOR_OP, 8'h80, 8'hFF, 1'b0, 1'b1);
    e = q.pop_front();
    vectors++;
    if (out_valid !== 1'b1 || out_data !== e.data || out_any !== (|e.data) ||
        out_err !== e.err || obs_beats !== e.beats) begin
      miscompares++;
      $display("FAIL acc_or_result: got v=%b d=%h err=%b beats=%0d, want v=1 d=%h err=%b beats=%0d",
               out_valid, out_data, out_err, obs_beats, e.data, e.err, e.beats);
    end
    // Restart: in_first in ACCUM drops the partial 0x01.
    send(AOR_OP, 8'h01, 8'h00, 1'b1, 1'b0);
    send(AOR_OP, 8'h40, 8'h00, 1'b1, 1'b0);
    push(8'h42, 1'b0, 3'd2);
    send(AOR_OP, 8'h02, 8'h00, 1'b0, 1'b1);
    e = q.pop_front();
    vectors++;
    if (out_valid !== 1'b1 || out_data !== e.data || obs_beats !== e.beats) begin
      miscompares++;
      $display("FAIL acc_restart: got v=%b d=%h beats=%0d, want v=1 d=%h beats=%0d",
               out_valid, out_data, obs_beats, e.data, e.beats);
    end
    // Long reduction: beat count saturates at 7.
    send(AOR_OP, 8'h01, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) send(AOR_OP, 8'h00, 8'h00, 1'b0, 1'b0);
    push(8'h81, 1'b0, 3'd7);
    send(AOR_OP, 8'h80, 8'h00, 1'b0, 1'b1);
    e = q.pop_front();
    vectors++;
    if (out_valid !== 1'b1 || out_data !== e.data || obs_beats !== e.beats) begin
      miscompares++;
      $display("FAIL acc_saturate: got v=%b d=%h beats=%0d, want v=1 d=%h beats=%0d",
               out_valid, out_data, obs_beats, e.data, e.beats);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    push(8'h55, 1'b0, 3'd1);
    send(AND_OP, 8'h55, 8'hFF, 1'b0, 1'b0);
    e = q.pop_front();
    vectors++;
    if (out_valid !== 1'b1 || out_data !== e.data) begin
      miscompares++;
      $display("FAIL hold_load: got v=%b d=%h, want v=1 d=%h", out_valid, out_data, e.data);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      vectors++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== e.data) begin
        miscompares++;
        $display("FAIL hold_cycle%0d: got rdy=%b v=%b d=%h, want rdy=0 v=1 d=%h",
                 i, in_ready, out_valid, out_data, e.data);
      end
    end
    out_ready = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL ready_on_pop: got %b want 1", in_ready);
    end
    push(8'h55, 1'b0, 3'd1);
    send(XOR_OP, 8'hAA, 8'hFF, 1'b0, 1'b0);
    e = q.pop_front();
    vectors++;
    if (out_valid !== 1'b1 || out_data !== e.data || out_any !== (|e.data)) begin
      miscompares++;
      $display("FAIL pop_push: got v=%b d=%h any=%b, want v=1 d=%h",
               out_valid, out_data, out_any, e.data);
    end
  endtask

  task automatic test_interleave();
    send(AXOR_OP, 8'h0F, 8'h00, 1'b1, 1'b0);
    push(8'h33, 1'b0, 3'd1);
    send(OR_OP, 8'h11, 8'h22, 1'b1, 1'b1);
    e = q.pop_front();
    vectors++;
    if (out_valid !== 1'b1 || out_data !== e.data || obs_beats !== e.beats) begin
      miscompares++;
      $display("FAIL interleave_or: got v=%b d=%h beats=%0d, want v=1 d=%h beats=%0d",
               out_valid, out_data, obs_beats, e.data, e.beats);
    end
    push(8'hFF, 1'b0, 3'd2);
    send(AXOR_OP, 8'hF0, 8'h00, 1'b0, 1'b1);
    e = q.pop_front();
    vectors++;
    if (out_valid !== 1'b1 || out_data !== e.data || obs_beats !== e.beats) begin
      miscompares++;
      $display("FAIL interleave_xor: got v=%b d=%h beats=%0d, want v=1 d=%h beats=%0d",
               out_valid, out_data, obs_beats, e.data, e.beats);
    end
  endtask

  task automatic test_reset_mid();
    send(AAND_OP, 8'hFF, 8'h00, 1'b1, 1'b0);
    send(AAND_OP, 8'h0F, 8'h00, 1'b0, 1'b0);
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_quiet: got out_valid=%b want 0", out_valid);
    end
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || out_any !== 1'b0 ||
        out_err !== 1'b0 || obs_beats !== 3'd0 || in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset: got v=%b d=%h any=%b err=%b beats=%0d rdy=%b, want all 0",
               out_valid, out_data, out_any, out_err, obs_beats, in_ready);
    end
    rst_n = 1'b1;
    // No in_first: the state must be back in IDLE for this to start afresh.
    push(8'h3C, 1'b0, 3'd1);
    send(AAND_OP, 8'h3C, 8'h00, 1'b0, 1'b1);
    e = q.pop_front();
    vectors++;
    if (out_valid !== 1'b1 || out_data !== e.data || obs_beats !== e.beats) begin
      miscompares++;
      $display("FAIL implicit_start: got v=%b d=%h beats=%0d, want v=1 d=%h beats=%0d",
               out_valid, out_data, obs_beats, e.data, e.beats);
    end
    push(8'h3C, 1'b0, 3'd1);
    send(AAND_OP, 8'h3C, 8'h00, 1'b1, 1'b1);
    e = q.pop_front();
    vectors++;
    if (out_valid !== 1'b1 || out_data !== e.data || obs_beats !== e.beats) begin
      miscompares++;
      $display("FAIL first_last: got v=%b d=%h beats=%0d, want v=1 d=%h beats=%0d",
               out_valid, out_data, obs_beats, e.data, e.beats);
    end
  endtask

  task automatic test_reserved();
    push(8'h5A, 1'b1, 3'd1);
    send(RSVD_OP, 8'h5A, 8'hFF, 1'b0, 1'b0);
    e = q.pop_front();
    vectors++;
    if (out_valid !== 1'b1 || out_data !== e.data || out_err !== e.err ||
        out_any !== (|e.data)) begin
      miscompares++;
      $display("FAIL rsvd: got v=%b d=%h err=%b any=%b, want v=1 d=%h err=%b",
               out_valid, out_data, out_err, out_any, e.data, e.err);
    end
    push(8'h0F, 1'b0, 3'd1);
    send(AND_OP, 8'hFF, 8'h0F, 1'b0, 1'b0);
    e = q.pop_front();
    vectors++;
    if (out_valid !== 1'b1 || out_data !== e.data || out_err !== e.err) begin
      miscompares++;
      $display("FAIL err_clear: got v=%b d=%h err=%b, want v=1 d=%h err=%b",
               out_valid, out_data, out_err, e.data, e.err);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_op     = 3'd0;
    in_a      = '0;
    in_b      = '0;
    in_first  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    test_reset();
    test_single();
    test_accum_or();
    test_backpressure();
    test_interleave();
    test_reset_mid();
    test_reserved();
    vectors++;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/logic_accum_unit.md
# logic_accum_unit

Parametrised, registered successor to the byte-wide bitwise gate blocks. Combines the AND/OR/XOR/NOT/any-bit-set functions into one WIDTH-bit unit with a valid/ready handshake. Adds multi-beat accumulating reductions, where a stream of operands is folded into a single result. Sits between an operand source and any consumer that needs bitwise results with backpressure.

## Interface
- WIDTH, 8, operand/result width in bits (≥1)
- CNT_W, 8, beat-counter width (used only with LOGIC_ACCUM_BEAT_COUNT_EN)
- clk  input  1  single clock, rising edge
- rst_n  input  1  reset, synchronous, active-low
- in_valid  input  1  operand beat present
- in_ready  output  1  unit accepts beat this cycle
- in_op  input  3  opcode (see Operation)
- in_a  input  WIDTH  operand A
- in_b  input  WIDTH  operand B (ignored by NOT, PASS and accumulate ops)
- in_first  input  1  accumulate ops: beat starts a new reduction
- in_last  input  1  accumulate ops: beat ends reduction, emits result
- out_valid  output  1  result held
- out_ready  input  1  consumer takes result
- out_data  output  WIDTH  result
- out_any  output  1  |out_data
- out_err  output  1  result came from reserved opcode
- out_beats  output  CNT_W  beats folded into result (macro only)

## Operation
- Opcodes:
  - 0 AND: A&B
  - 1 OR: A|B
  - 2 XOR: A^B
  - 3 NOT: ~A
  - 4 ACC_AND
  - 5 ACC_OR
  - 6 ACC_XOR
  - 7 reserved: result = A, out_err = 1
- Beat accepted when in_valid && in_ready.
- in_ready = rst_n && (!out_valid || out_ready). The rule is uniform for all opcodes.
- Single-beat ops (0–3, 7):
  - Each accepted beat loads the output register.
  - in_first/in_last are ignored.
  - The accumulator and FSM state are untouched.
- FSM states: IDLE, ACCUM.
- Accumulate ops (4–6): op is per beat; acc_next = acc op A, or A if starting.
  - A beat starts when in_first = 1 or state = IDLE. IDLE without in_first is an implicit start.
  - in_first in ACCUM discards the partial and restarts.
  - in_last = 0: acc updated, state → ACCUM, no output.
  - in_last = 1: output register ← acc_next, state → IDLE, acc cleared to 0.
  - in_first && in_last: result = A.
- Output register holds until out_valid && out_ready.
- Simultaneous pop and push in the same cycle: the new result replaces the old one and out_valid stays 1.

## Timing
- Latency: one cycle from accepting a result-producing beat to out_valid = 1 with its data.
- Throughput: one beat per cycle when out_ready = 1.
- While rst_n = 0 at a clock edge:
  - out_valid, out_data, out_any, out_err and out_beats reset to 0.
  - acc resets to 0 and the state resets to IDLE.
  - in_ready = 0.
- Reset mid-reduction drops the partial with no output.
- out_data, out_any and out_err change only on a load or reset.
- Stable while out_valid && !out_ready.

## Configuration
- LOGIC_ACCUM_BEAT_COUNT_EN defined:
  - out_beats port exists.
  - A counter is loaded with 1 at each start and incremented on each accumulate beat, saturating at 2^CNT_W−1.
  - Its value is registered with the result; single-beat results report 1.
- Undefined: out_beats port and counter are absent; all other behaviour is identical.

## Structure
- Package logic_unit_pkg holds:
  - op_e enum (OP_AND … OP_RSVD, 3 bits)
  - state_e enum (IDLE, ACCUM)
  - opcode-class helper is_accum(op)
- Sub-module logic_op_core: combinational, WIDTH-parametrised, (op, a, b) → y.
  - Shared by the single-beat path and the accumulator fold; the fold calls it with b = acc.

## Test plan
- WIDTH=8, out_ready=1. AND A=0xF0,B=0x3C → next cycle out_data=0x30, out_any=1, out_err=0; NOT A=0xFF → 0x00, out_any=0.
- ACC_OR beats 0x01(first), 0x02, 0x80(last) → single result 0x83 one cycle after last beat, no earlier out_valid; out_beats=3 with macro.
- out_ready=0 after result 0x55 → in_ready=0, out_data holds 0x55 for 5 cycles; raise out_ready with pending XOR 0xAA^0xFF → same-cycle pop/push, next out_data=0x55 (new), out_valid stays 1.
- ACC_XOR 0x0F(first), then OR 0x11,0x22 single-beat, then ACC_XOR 0xF0(last) → outputs 0x33 then 0xFF; accumulator undisturbed.
- ACC_AND 0xFF(first), 0x0F, then rst_n=0 one cycle, then ACC_AND 0x3C(first,last) → no output before reset, all outputs 0 after reset, then result 0x3C.
- Opcode 7 A=0x5A → out_data=0x5A, out_err=1; following AND clears out_err.
